// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: any DEPTH >= 2, programmable almost thresholds, occupancy count
// and per-edge ack/overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = 7,
    parameter int AE_TH      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         wr_ack,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         full,
    output logic                         empty,
    output logic                         almostfull,
    output logic                         almostempty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_ok, rd_ok;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(AF_TH)) && !full;
    assign almostempty = !empty && (count_q <= CW'(AE_TH));
    assign count       = count_q;

    // A read on the same edge frees a slot, so a full FIFO still accepts the write.
    assign wr_ok = wr_en & (~full | rd_en);
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ok;
            overflow_q  <= wr_en & ~wr_ok;
            underflow_q <= rd_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wr_ptr_q] <= data_in;
    end

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; meaningless while empty.
    assign data_out = mem[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (rst)        data_out_q <= '0;
        else if (rd_ok) data_out_q <= mem[rd_ptr_q];
    end

    assign data_out = data_out_q;
`endif

endmodule
